// File: rtl/mem_stage_lat_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_lat_if
// Brief   : M-stage request bundle and registered MEM/WB result bundle.
// Rev     : 1.0  initial release
// ============================================================================
interface mem_stage_lat_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
);
    logic              mem_req_m;
    logic              mem_write_m;
    logic              byte_m;
    logic              load_signed_m;
    logic [DATA_W-1:0] alu_result_m;
    logic [DATA_W-1:0] write_data_m;
    logic [REG_AW-1:0] rd_m;
    logic              reg_write_m;

    logic              stall_m;
    logic [DATA_W-1:0] read_data_w;
    logic [DATA_W-1:0] alu_result_w;
    logic [REG_AW-1:0] rd_w;
    logic              reg_write_w;
    logic              mem_to_reg_w;
    logic              addr_err_w;

    modport master (
        output mem_req_m, mem_write_m, byte_m, load_signed_m,
               alu_result_m, write_data_m, rd_m, reg_write_m,
        input  stall_m, read_data_w, alu_result_w, rd_w,
               reg_write_w, mem_to_reg_w, addr_err_w
    );

    modport slave (
        input  mem_req_m, mem_write_m, byte_m, load_signed_m,
               alu_result_m, write_data_m, rd_m, reg_write_m,
        output stall_m, read_data_w, alu_result_w, rd_w,
               reg_write_w, mem_to_reg_w, addr_err_w
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lat.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_lat
// Brief   : Pipeline M stage: data RAM with word/byte access, multi-cycle
//           latency with upstream stall, registered MEM/WB outputs.
// Rev     : 1.0  initial release
// ============================================================================
module mem_stage_lat #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int REG_AW  = 3
) (
    input  wire logic       clk,
    input  wire logic       reset,
    mem_stage_lat_if.slave  bus
);
    localparam int c_B      = DATA_W / 8;
    localparam int c_LSB    = $clog2(c_B);
    localparam int c_LANE_W = (c_LSB > 0) ? c_LSB : 1;
    localparam int c_IDX_W  = $clog2(DEPTH);
    localparam int c_TOP    = c_LSB + c_IDX_W;
    localparam int c_CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(LATENCY - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_count;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [DATA_W-1:0]   r_readData;
    logic [DATA_W-1:0]   r_aluResult;
    logic [REG_AW-1:0]   r_rd;
    logic                r_regWrite;
    logic                r_memToReg;
    logic                r_addrErr;

    logic [c_LANE_W-1:0] w_lane;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_outOfRange;
    logic                w_misaligned;
    logic                w_legal;
    logic                w_memOp;
    logic                w_illegal;
    logic                w_done;
    logic                w_complete;
    logic [DATA_W-1:0]   w_rdWord;
    logic [7:0]          w_rdByte;
    logic [DATA_W-1:0]   w_loadVal;

    // ---------------------------------------------------------------- decode
    generate
        if (c_LSB > 0) begin : g_multiLane
            assign w_lane = bus.alu_result_m[c_LSB-1:0];
        end else begin : g_singleLane
            assign w_lane = '0;
        end

        if (c_TOP < DATA_W) begin : g_rangeChk
            assign w_outOfRange = |bus.alu_result_m[DATA_W-1:c_TOP];
        end else begin : g_noRangeChk
            assign w_outOfRange = 1'b0;
        end

        if (LATENCY == 1) begin : g_singleCycle
            assign w_done = 1'b1;
        end else begin : g_multiCycle
            assign w_done = (r_state == ST_BUSY) && (r_count == c_LAST);
        end
    endgenerate

    assign w_idx        = bus.alu_result_m[c_LSB +: c_IDX_W];
    assign w_misaligned = ~bus.byte_m & (w_lane != '0);
    assign w_legal      = ~w_misaligned & ~w_outOfRange;
    assign w_memOp      = bus.mem_req_m & w_legal;
    assign w_illegal    = bus.mem_req_m & ~w_legal;
    assign w_complete   = w_memOp & w_done;

    // Gated by reset so an aborted access drops its stall immediately.
    assign bus.stall_m  = reset & w_memOp & ~w_done;

    // ------------------------------------------------------- latency counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_memOp && (LATENCY > 1)) begin
                        r_state <= ST_BUSY;
                        r_count <= c_CNT_W'(1);
                    end
                end
                ST_BUSY: begin
                    if (r_count == c_LAST) begin
                        r_state <= ST_IDLE;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------- data RAM
    always_ff @(posedge clk) begin
        if (reset && w_complete && bus.mem_write_m) begin
            for (int l = 0; l < c_B; l++) begin
                if (!bus.byte_m)
                    r_mem[w_idx][8*l +: 8] <= bus.write_data_m[8*l +: 8];
                else if (w_lane == c_LANE_W'(l))
                    r_mem[w_idx][8*l +: 8] <= bus.write_data_m[7:0];
            end
        end
    end

    // Read path sees pre-write contents because it is captured at the same edge.
    assign w_rdWord = r_mem[w_idx];

    always_comb begin
        w_rdByte = w_rdWord[7:0];
        for (int l = 0; l < c_B; l++) begin
            if (w_lane == c_LANE_W'(l))
                w_rdByte = w_rdWord[8*l +: 8];
        end
    end

    assign w_loadVal = bus.byte_m
                     ? {{(DATA_W-8){bus.load_signed_m & w_rdByte[7]}}, w_rdByte}
                     : w_rdWord;

    // ---------------------------------------------------------- MEM/WB regs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_readData  <= '0;
            r_aluResult <= '0;
            r_rd        <= '0;
            r_regWrite  <= 1'b0;
            r_memToReg  <= 1'b0;
            r_addrErr   <= 1'b0;
        end else if (!bus.mem_req_m) begin
            r_readData  <= '0;
            r_aluResult <= bus.alu_result_m;
            r_rd        <= bus.rd_m;
            r_regWrite  <= bus.reg_write_m;
            r_memToReg  <= 1'b0;
            r_addrErr   <= 1'b0;
        end else if (w_illegal) begin
            r_readData  <= '0;
            r_aluResult <= bus.alu_result_m;
            r_rd        <= bus.rd_m;
            r_regWrite  <= 1'b0;
            r_memToReg  <= 1'b0;
            r_addrErr   <= 1'b1;
        end else if (w_done) begin
            r_readData  <= bus.mem_write_m ? '0 : w_loadVal;
            r_aluResult <= bus.alu_result_m;
            r_rd        <= bus.rd_m;
            r_regWrite  <= bus.reg_write_m;
            r_memToReg  <= ~bus.mem_write_m;
            r_addrErr   <= 1'b0;
        end else begin
            r_regWrite  <= 1'b0;
            r_memToReg  <= 1'b0;
            r_addrErr   <= 1'b0;
        end
    end

    assign bus.read_data_w  = r_readData;
    assign bus.alu_result_w = r_aluResult;
    assign bus.rd_w         = r_rd;
    assign bus.reg_write_w  = r_regWrite;
    assign bus.mem_to_reg_w = r_memToReg;
    assign bus.addr_err_w   = r_addrErr;

endmodule
`default_nettype wire
